ds_modulator_cifb: RTL and testbench

// Parametrised single-bit delta-sigma modulator, CIFB topology with optional resonators, for the DAC/audio path.

---
 rtl/ds_modulator_cifb.sv | 149 ++++++++++++++
 tb/tb_ds_modulator_cifb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ds_modulator_cifb.sv
// Single-bit CIFB delta-sigma modulator with optional resonators, saturating
// integrators and automatic recovery from sustained integrator saturation.
module ds_modulator_cifb #(
    parameter int ORDER       = 5,
    parameter int DW          = 24,
    parameter int IW          = 41,
    parameter int CW          = 18,
    parameter int COEF_FRAC   = 16,
    parameter int FS          = 2**23,
    parameter logic [CW-1:0] B_COEF = CW'(65536),
    parameter logic [ORDER*CW-1:0] A_COEF = {ORDER{CW'(65536)}},
    parameter logic [ORDER*CW-1:0] C_COEF = {ORDER{CW'(65536)}},
    parameter logic [((ORDER/2 > 0) ? ORDER/2 : 1)*CW-1:0] G_COEF = '0,
    parameter int SAT_LIMIT   = 64,
    parameter int RECOVER_LEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DW-1:0]    din,
    output logic             dout,
    output logic             recovering,
    output logic [ORDER-1:0] sat_flags,
    output logic [15:0]      recover_count
);
    localparam int PW  = IW + 2;
    localparam int SCW = $clog2(SAT_LIMIT + 1);
    localparam int RCW = (RECOVER_LEN > 1) ? $clog2(RECOVER_LEN) : 1;
    localparam logic signed [PW-1:0] SMAX = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = -SMAX;
    localparam logic signed [PW-1:0] FS_P = PW'(FS);

    typedef enum logic {RUN, RECOVER} state_e;

    function automatic logic signed [PW-1:0] prod(input logic signed [PW-1:0] x,
                                                  input logic [CW-1:0] c);
        logic signed [PW+CW-1:0] p;
        p = $signed({{CW{x[PW-1]}}, x}) * $signed({{PW{c[CW-1]}}, c});
        p = p >>> COEF_FRAC;
        return p[PW-1:0];
    endfunction

    function automatic logic signed [PW-1:0] sx(input logic [IW-1:0] a);
        return PW'($signed(a));
    endfunction

    state_e                   state_q, state_d;
    logic [ORDER-1:0][IW-1:0] integ_q, integ_d, integ_run;
    logic [ORDER-1:0]         flags_q, flags_d, clamp;
    logic [SCW-1:0]           sat_cnt_q, sat_cnt_d;
    logic [RCW-1:0]           rec_cnt_q, rec_cnt_d;
    logic [15:0]              rcount_q, rcount_d;
    logic                     dout_q, dout_d;
    logic signed [PW-1:0]     fb_out, v;
    logic                     q;

    assign fb_out = prod(sx(integ_q[ORDER-1]), C_COEF[(ORDER-1)*CW +: CW]);
    assign q      = ~fb_out[PW-1];
    assign v      = q ? FS_P : -FS_P;

    for (genvar n = 0; n < ORDER; n++) begin : g_stage
        logic signed [PW-1:0] src, res, sum;
        if (n == 0) begin : g_in
            assign src = prod(PW'($signed(din)), B_COEF);
        end else begin : g_chain
            assign src = prod(sx(integ_q[n-1]), C_COEF[(n-1)*CW +: CW]);
        end
        // Resonator feedback from the following integrator on even 1-based stages.
        if ((n % 2 == 1) && (n < ORDER - 1)) begin : g_res
            assign res = prod(sx(integ_q[n+1]), G_COEF[((n+1)/2-1)*CW +: CW]);
        end else begin : g_nores
            assign res = '0;
        end
        assign sum          = sx(integ_q[n]) + src - prod(v, A_COEF[n*CW +: CW]) - res;
        assign clamp[n]     = (sum > SMAX) || (sum < SMIN);
        assign integ_run[n] = (sum > SMAX) ? SMAX[IW-1:0] :
                              (sum < SMIN) ? SMIN[IW-1:0] : sum[IW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        integ_d   = integ_q;
        flags_d   = flags_q;
        sat_cnt_d = sat_cnt_q;
        rec_cnt_d = rec_cnt_q;
        rcount_d  = rcount_q;
        dout_d    = dout_q;
        if (enable) begin
            case (state_q)
                RUN: begin
                    dout_d  = q;
                    flags_d = clamp;
                    integ_d = integ_run;
                    if (|clamp) begin
                        if (sat_cnt_q == SCW'(SAT_LIMIT - 1)) begin
                            state_d   = RECOVER;
                            integ_d   = '0;
                            sat_cnt_d = '0;
                            rec_cnt_d = '0;
                            if (rcount_q != 16'hFFFF) rcount_d = rcount_q + 16'd1;
                        end else begin
                            sat_cnt_d = sat_cnt_q + 1'b1;
                        end
                    end else begin
                        sat_cnt_d = '0;
                    end
                end
                RECOVER: begin
                    // Alternating bits keep the output zero-mean while the loop is flushed.
                    dout_d  = ~rec_cnt_q[0];
                    flags_d = '0;
                    integ_d = '0;
                    if (rec_cnt_q == RCW'(RECOVER_LEN - 1)) begin
                        state_d   = RUN;
                        rec_cnt_d = '0;
                    end else begin
                        rec_cnt_d = rec_cnt_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            integ_q   <= '0;
            flags_q   <= '0;
            sat_cnt_q <= '0;
            rec_cnt_q <= '0;
            rcount_q  <= '0;
            dout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            integ_q   <= integ_d;
            flags_q   <= flags_d;
            sat_cnt_q <= sat_cnt_d;
            rec_cnt_q <= rec_cnt_d;
            rcount_q  <= rcount_d;
            dout_q    <= dout_d;
        end
    end

    assign dout          = dout_q;
    assign recovering    = (state_q == RECOVER);
    assign sat_flags     = flags_q;
    assign recover_count = rcount_q;
endmodule

// File: tb/tb_ds_modulator_cifb.sv
// Randomised scoreboard bench: a longint arithmetic model of the CIFB loop predicts
// every post-edge output; a monitor pops and compares after each rising edge.
module tb_ds_modulator_cifb;
    localparam int ORDER = 3, DW = 24, IW = 26, CW = 18, CF = 16, FS = 2**23;
    localparam int SATL = 4, RLEN = 32, PW = IW + 2;
    localparam int BC = 65536, A1 = 65536, A2 = 98304, A3 = 40000;
    localparam int C1 = 49152, C2 = 65536, C3 = 65536, G1 = -1500;
    localparam longint AC[ORDER] = '{A1, A2, A3};
    localparam longint CC[ORDER] = '{C1, C2, C3};
    localparam longint GC[1]     = '{G1};

    logic clk = 1'b0;
    logic rst, enable;
    logic [DW-1:0] din;
    logic dout, recovering;
    logic [ORDER-1:0] sat_flags;
    logic [15:0] recover_count;

    always #5 clk = ~clk;

    ds_modulator_cifb #(
        .ORDER(ORDER), .DW(DW), .IW(IW), .CW(CW), .COEF_FRAC(CF), .FS(FS),
        .B_COEF(CW'(BC)),
        .A_COEF({CW'(A3), CW'(A2), CW'(A1)}),
        .C_COEF({CW'(C3), CW'(C2), CW'(C1)}),
        .G_COEF(CW'(G1)),
        .SAT_LIMIT(SATL), .RECOVER_LEN(RLEN)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .din(din),
        .dout(dout), .recovering(recovering), .sat_flags(sat_flags),
        .recover_count(recover_count)
    );

    typedef struct packed {
        logic             dout;
        logic             rec;
        logic [ORDER-1:0] flags;
        logic [15:0]      rc;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    bit injected = 0;

    longint mi[ORDER];
    bit mdout, mrec;
    logic [ORDER-1:0] mflags;
    int msat, mrecn, mrc;

    function automatic longint wrapw(longint x);
        longint m;
        m = x & ((64'sd1 <<< PW) - 1);
        if (m >= (64'sd1 <<< (PW - 1))) m -= (64'sd1 <<< PW);
        return m;
    endfunction

    function automatic longint prodm(longint x, longint c);
        return wrapw((x * c) >>> CF);
    endfunction

    task automatic model_step(input bit r, input bit en, input longint d);
        longint nx[ORDER];
        longint fb, vv, s, lim;
        logic [ORDER-1:0] f;
        lim = (64'sd1 <<< (IW - 1)) - 1;
        if (r) begin
            foreach (mi[k]) mi[k] = 0;
            mdout = 0; mrec = 0; mflags = '0; msat = 0; mrecn = 0; mrc = 0;
            return;
        end
        if (!en) return;
        if (mrec) begin
            mdout  = (mrecn % 2 == 0);
            mflags = '0;
            foreach (mi[k]) mi[k] = 0;
            mrecn++;
            if (mrecn == RLEN) begin mrec = 0; mrecn = 0; end
            return;
        end
        fb = prodm(mi[ORDER-1], CC[ORDER-1]);
        vv = (fb >= 0) ? FS : -FS;
        f  = '0;
        for (int k = 0; k < ORDER; k++) begin
            s = (k == 0) ? prodm(d, BC) : prodm(mi[k-1], CC[k-1]);
            s -= prodm(vv, AC[k]);
            if (((k + 1) % 2 == 0) && (k + 1 < ORDER)) s -= prodm(mi[k+1], GC[(k+1)/2-1]);
            s = wrapw(mi[k] + s);
            if (s > lim) begin s = lim; f[k] = 1'b1; end
            else if (s < -lim) begin s = -lim; f[k] = 1'b1; end
            nx[k] = s;
        end
        mdout  = (fb >= 0);
        mflags = f;
        mi     = nx;
        if (f != '0) begin
            msat++;
            if (msat >= SATL) begin
                mrec = 1; msat = 0; mrecn = 0;
                foreach (mi[k]) mi[k] = 0;
                if (mrc < 65535) mrc++;
            end
        end else begin
            msat = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit en, input longint d);
        exp_t e;
        rst = r; enable = en; din = DW'(d);
        model_step(r, en, d);
        e.dout = mdout; e.rec = mrec; e.flags = mflags; e.rc = 16'(mrc);
        sb.push_back(e);
        @(negedge clk);
    endtask

    function automatic longint rs(int amp);
        return longint'($urandom_range(0, 2 * amp)) - amp;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", 16'(dout), 16'(e.dout));
                chk("recovering", 16'(recovering), 16'(e.rec));
                chk("sat_flags", 16'(sat_flags), 16'(e.flags));
                chk("recover_count", recover_count, e.rc);
            end
        end
    end

    initial begin
        repeat (3) cyc(1, 1, 0);
        repeat (200) cyc(0, 1, 0);
        repeat (800) cyc(0, $urandom_range(3) != 0, rs(1 << 20));
        // Full-scale DC drives the loop unstable; reset once at RECOVER cycle 10.
        repeat (600) begin
            if (!injected && mrec && mrecn == 10) begin
                injected = 1;
                cyc(1, 1, 8388607);
            end else begin
                cyc(0, $urandom_range(7) != 0, 8388607 - longint'($urandom_range(0, 1000)));
            end
        end
        repeat (600) cyc($urandom_range(99) == 0, $urandom_range(1) == 1, rs(8388607));
        repeat (300) cyc(0, 1, -8388608);
        repeat (200) cyc(0, $urandom_range(2) != 0, rs(1 << 18));
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d pending expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
